// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store engine: lane steering, byte enables, load extension,
// and misaligned/illegal/timeout error reporting over a req/gnt + rvalid memory port.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ready,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept, accept_err, gnt_take, load_take, timeout;
    logic             cnt_clr, cnt_inc;
    logic             err_q, we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      res_q;

    function automatic logic is_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic illegal, misaligned;
        illegal    = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] sb, sh;
        b  = word[{off, 3'b000} +: 8];
        h  = off[1] ? word[31:16] : word[15:0];
        sb = $signed(b);
        sh = $signed(h);
        case (f3)
            3'b000:  return sb;
            3'b001:  return sh;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    assign core_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        accept_err = 1'b0;
        gnt_take   = 1'b0;
        load_take  = 1'b0;
        timeout    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: if (core_req) begin
                accept = 1'b1;
                if (is_bad(core_we, core_funct3, core_addr[1:0])) begin
                    accept_err = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    cnt_clr   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    gnt_take  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = we_q ? DONE : RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    load_take = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and externally visible registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= '0;
            err_q      <= 1'b0;
        end else begin
            core_done <= (state == DONE);
            if (state == DONE) begin
                core_err   <= err_q;
                core_rdata <= res_q;
            end
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
            if (accept) begin
                err_q <= accept_err;
                if (!accept_err) begin
                    mem_req   <= 1'b1;
                    mem_we    <= core_we;
                    mem_addr  <= {core_addr[31:2], 2'b00};
                    mem_be    <= lane_be(core_funct3, core_addr[1:0]);
                    mem_wdata <= lane_wdata(core_funct3, core_wdata);
                end
            end
            if (gnt_take || timeout) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (timeout) err_q <= 1'b1;
        end
    end

    // Access attributes and load result; pure data, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q  <= core_we;
            f3_q  <= core_funct3;
            off_q <= core_addr[1:0];
            res_q <= '0;
        end
        if (timeout)   res_q <= '0;
        if (load_take) res_q <= load_extend(f3_q, off_q, mem_rdata);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a spec-level access model.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata;
    logic        core_ready, core_done, core_err;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err),
        .core_rdata(core_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One core access; d = cycles gnt is withheld, r = extra cycles before rvalid.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] word,
                              input int d, input int r, input bit rv_at_gnt);
        int          size, off, exp_done, exp_reqc, cyc, reqc, done_cyc;
        bit          bad, to_req, to_resp, exp_err, done_seen;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd, got_rd;
        logic [63:0] v, mask;
        logic        got_err;

        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr[1:0]);
        bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) || (off % size != 0);
        exp_be = '0;
        for (int k = 0; k < 4; k++) if (k >= off && k < off + size) exp_be[k] = 1'b1;
        if (size == 4) exp_be = 4'hF;
        for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % size) +: 8];
        mask = (64'd1 << (8 * size)) - 1;
        v    = ({32'b0, word} >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        to_req  = !bad && d >= T;
        to_resp = !bad && !to_req && !we && r >= T;
        exp_err = bad || to_req || to_resp;
        exp_rd  = exp_err ? 32'h0 : v[31:0];
        if (bad)          begin exp_done = 1;         exp_reqc = 0;     end
        else if (to_req)  begin exp_done = T + 1;     exp_reqc = T;     end
        else if (we)      begin exp_done = d + 2;     exp_reqc = d + 1; end
        else if (to_resp) begin exp_done = d + T + 2; exp_reqc = d + 1; end
        else              begin exp_done = d + r + 3; exp_reqc = d + 1; end

        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        step();
        core_req = 1'b0;
        cyc = 0; reqc = 0; done_seen = 0; done_cyc = -1; got_err = 1'b0; got_rd = '0;
        while (cyc < 40 && !done_seen) begin
            if (mem_req) begin
                reqc++;
                check_val("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check_val("mem_be", 32'(mem_be), 32'(exp_be));
                check_val("mem_wdata", mem_wdata, exp_wd);
                check_val("mem_we", 32'(mem_we), 32'(we));
            end
            if (core_done) begin
                done_seen = 1; done_cyc = cyc; got_err = core_err; got_rd = core_rdata;
            end
            mem_gnt    = mem_req && (d < T) && (cyc == d);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (!we && !bad && d < T && r < T && cyc == d + 1 + r) begin
                mem_rvalid = 1'b1; mem_rdata = word;
            end else if (rv_at_gnt && mem_gnt) begin
                mem_rvalid = 1'b1; mem_rdata = ~word;
            end
            step();
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_val("done_seen", 32'(done_seen), 32'd1);
        check_val("done_cycle", 32'(done_cyc), 32'(exp_done));
        check_val("err", 32'(got_err), 32'(exp_err));
        check_val("req_cycles", 32'(reqc), 32'(exp_reqc));
        if (exp_err || !we) check_val("rdata", got_rd, exp_rd);
        check_val("done_pulse", 32'(core_done), 32'd0);
        check_val("rdata_hold", core_rdata, got_rd);
    endtask

    initial begin
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_funct3 = '0;
        core_addr = '0; core_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_ready", 32'(core_ready), 32'd1);
        check_val("rst_done", 32'(core_done), 32'd0);
        check_val("rst_err", 32'(core_err), 32'd0);
        check_val("rst_rdata", core_rdata, 32'd0);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_be", 32'(mem_be), 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);

        run_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 0);
        run_access(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 0);
        run_access(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 0);
        run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1);
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h12F4_5678, 1, 2, 1);
        run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, 0);
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1, 0, 0, 0);
        run_access(1'b1, 3'b001, 32'h203, 32'h1234, 32'h0, 0, 0, 0);
        run_access(1'b1, 3'b110, 32'h200, 32'h1234, 32'h0, 0, 0, 0);
        run_access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0, 0);
        run_access(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h0, 3, 0, 0);
        run_access(1'b1, 3'b001, 32'h302, 32'h0000_BEEF, 32'h0, T, 0, 0);
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 0, T, 0);
        run_access(1'b0, 3'b000, 32'h401, 32'h0, 32'hCAFE_F00D, 2, T - 1, 0);

        // Stray rvalid while idle must not complete anything
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("idle_rvalid_done", 32'(core_done), 32'd0);
        end
        mem_rvalid = 1'b0;

        // Reset while waiting for load data
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h500;
        step();
        core_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rst_mid_req", 32'(mem_req), 32'd0);
        check_val("rst_mid_done", 32'(core_done), 32'd0);
        check_val("rst_mid_ready", 32'(core_ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("late_rvalid_done", 32'(core_done), 32'd0);
            step();
        end
        run_access(1'b0, 3'b101, 32'h602, 32'h0, 32'hABCD_0123, 1, 1, 0);

        for (int n = 0; n < 200; n++) begin
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                       $urandom, $urandom_range(0, T), $urandom_range(0, T),
                       1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
